// File: rtl/mole_round_ctrl.sv
// mole_round_ctrl
// Runs one whack-a-mole game. It takes the free-running hole index from the
// random generator, raises one mole at a time for a bounded window, and
// detects the player's strike. It keeps score and misses until the game ends.
//
// Optional build macro: MOLE_SPEEDUP_EN
//   Each hit shrinks the up-window by UP_CYCLES/16, with a floor of
//   UP_CYCLES/4. When the macro is undefined the window is always UP_CYCLES.
//
// Ports:
//   clk        in   system clock, rising edge
//   reset_n    in   synchronous active-low reset
//   start      in   level; begins a game from IDLE or OVER
//   rand_idx   in   [1:0] hole index, sampled only in SPAWN
//   btn        in   [3:0] debounced button levels, one per hole
//   mole       out  [3:0] one-hot raised mole, 0 when none
//   score      out  [SCORE_W-1:0] hits this game (saturating)
//   miss_cnt   out  [3:0] misses this game
//   hit_pulse  out  one-cycle pulse per successful hit
//   miss_pulse out  one-cycle pulse per timeout
//   game_over  out  high while in OVER
//   busy       out  high in every state except IDLE and OVER
module mole_round_ctrl #(
    parameter int UP_CYCLES  = 50_000_000,
    parameter int GAP_CYCLES = 25_000_000,
    parameter int MAX_MISSES = 3,
    parameter int SCORE_W    = 8
) (
    input  logic               clk,
    input  logic               reset_n,
    input  logic               start,
    input  logic [1:0]         rand_idx,
    input  logic [3:0]         btn,
    output logic [3:0]         mole,
    output logic [SCORE_W-1:0] score,
    output logic [3:0]         miss_cnt,
    output logic               hit_pulse,
    output logic               miss_pulse,
    output logic               game_over,
    output logic               busy
);

    localparam int MAXC = (UP_CYCLES > GAP_CYCLES) ? UP_CYCLES : GAP_CYCLES;
    localparam int TW   = $clog2(MAXC + 1);

    localparam logic [TW-1:0] GAP_LAST = TW'(GAP_CYCLES - 1);
    localparam logic [3:0]    MISS_END = 4'(MAX_MISSES);

    typedef enum logic [2:0] {
        S_IDLE,
        S_SPAWN,
        S_UP,
        S_HIT,
        S_MISS,
        S_GAP,
        S_OVER
    } state_t;

    state_t          state;
    state_t          state_nxt;
    logic [TW-1:0]   timer;
    logic [TW-1:0]   up_last;
    logic [1:0]      hole;
    logic [1:0]      spawn_hole;
    logic            first_mole;
    logic [3:0]      btn_q;
    logic            strike;
    logic            game_start;

    assign game_start = ((state == S_IDLE) || (state == S_OVER)) && start;

    // The hole register also serves as the previous hole for the anti-repeat
    // rule. A repeat is skipped by moving one hole on, except on the first
    // mole of a game.
    assign spawn_hole = (!first_mole && (rand_idx == hole)) ? rand_idx + 2'd1 : rand_idx;

    // A strike needs a rising edge, so a button already held when UP begins
    // does not count.
    assign strike = (state == S_UP) && btn[hole] && !btn_q[hole];

`ifdef MOLE_SPEEDUP_EN
    localparam logic [TW-1:0] UP_FULL  = TW'(UP_CYCLES);
    localparam logic [TW-1:0] UP_STEP  = TW'(UP_CYCLES / 16);
    localparam logic [TW-1:0] UP_FLOOR = TW'(UP_CYCLES / 4);

    logic [TW-1:0] up_limit;

    // The window shrinks on every hit down to the floor. A miss leaves it alone.
    always_ff @(posedge clk) begin
        if (!reset_n) begin
            up_limit <= UP_FULL;
        end else if (game_start) begin
            up_limit <= UP_FULL;
        end else if (state == S_HIT) begin
            if (up_limit >= UP_FLOOR + UP_STEP) begin
                up_limit <= up_limit - UP_STEP;
            end else begin
                up_limit <= UP_FLOOR;
            end
        end
    end

    assign up_last = up_limit - TW'(1);
`else
    assign up_last = TW'(UP_CYCLES - 1);
`endif

    // State register, game counters, and the button edge history.
    // The timer runs only while UP or GAP stays in place. It reads 0 on
    // entry to either state.
    always_ff @(posedge clk) begin
        if (!reset_n) begin
            state      <= S_IDLE;
            timer      <= '0;
            hole       <= 2'd0;
            first_mole <= 1'b1;
            score      <= '0;
            miss_cnt   <= 4'd0;
            btn_q      <= btn;
        end else begin
            state <= state_nxt;
            btn_q <= btn;

            if (((state == S_UP) || (state == S_GAP)) && (state_nxt == state)) begin
                timer <= timer + TW'(1);
            end else begin
                timer <= '0;
            end

            case (state)
                S_IDLE, S_OVER: begin
                    if (start) begin
                        score      <= '0;
                        miss_cnt   <= 4'd0;
                        first_mole <= 1'b1;
                    end
                end
                S_SPAWN: begin
                    hole       <= spawn_hole;
                    first_mole <= 1'b0;
                end
                S_HIT: begin
                    if (score != {SCORE_W{1'b1}}) begin
                        score <= score + SCORE_W'(1);
                    end
                end
                S_MISS: begin
                    miss_cnt <= miss_cnt + 4'd1;
                end
                default: begin
                end
            endcase
        end
    end

    // Next-state logic. A strike on the timeout cycle still wins over the miss.
    always_comb begin
        state_nxt = state;
        case (state)
            S_IDLE, S_OVER: begin
                if (start) begin
                    state_nxt = S_SPAWN;
                end
            end
            S_SPAWN: state_nxt = S_UP;
            S_UP: begin
                if (strike) begin
                    state_nxt = S_HIT;
                end else if (timer == up_last) begin
                    state_nxt = S_MISS;
                end
            end
            S_HIT: state_nxt = S_GAP;
            S_MISS: begin
                if (miss_cnt + 4'd1 == MISS_END) begin
                    state_nxt = S_OVER;
                end else begin
                    state_nxt = S_GAP;
                end
            end
            S_GAP: begin
                if (timer == GAP_LAST) begin
                    state_nxt = S_SPAWN;
                end
            end
            default: state_nxt = S_IDLE;
        endcase
    end

    // Outputs are decoded from the state alone.
    always_comb begin
        mole       = 4'b0000;
        hit_pulse  = 1'b0;
        miss_pulse = 1'b0;
        game_over  = 1'b0;
        busy       = 1'b1;
        case (state)
            S_IDLE: busy = 1'b0;
            S_OVER: begin
                busy      = 1'b0;
                game_over = 1'b1;
            end
            S_UP:   mole       = 4'b0001 << hole;
            S_HIT:  hit_pulse  = 1'b1;
            S_MISS: miss_pulse = 1'b1;
            default: begin
            end
        endcase
    end

endmodule

// File: tb/tb_mole_round_ctrl.sv
// Testbench for mole_round_ctrl.
// It plays a directed game from a vector table, then a few hand sequences
// (saturation, start while busy, reset in UP), then randomized games.
// The expected results come from a mole-level model: hole choice rule,
// window length, and score/miss tallies.
module tb_mole_round_ctrl;

`ifdef MOLE_SPEEDUP_EN
    localparam int UP = 64;
`else
    localparam int UP = 8;
`endif
    localparam int GAP  = 4;
    localparam int MAXM = 3;

    logic       clk = 1'b0;
    logic       reset_n = 1'b0;
    logic       start = 1'b0;
    logic [1:0] rand_idx = 2'd0;
    logic [3:0] btn = 4'd0;

    logic [3:0] mole, mole2;
    logic [7:0] score;
    logic [1:0] score2;
    logic [3:0] miss_cnt, miss_cnt2;
    logic       hit_pulse, hit_pulse2, miss_pulse, miss_pulse2;
    logic       game_over, game_over2, busy, busy2;

    mole_round_ctrl #(.UP_CYCLES(UP), .GAP_CYCLES(GAP), .MAX_MISSES(MAXM), .SCORE_W(8)) dut (
        .clk(clk), .reset_n(reset_n), .start(start), .rand_idx(rand_idx), .btn(btn),
        .mole(mole), .score(score), .miss_cnt(miss_cnt), .hit_pulse(hit_pulse),
        .miss_pulse(miss_pulse), .game_over(game_over), .busy(busy)
    );

    mole_round_ctrl #(.UP_CYCLES(UP), .GAP_CYCLES(GAP), .MAX_MISSES(MAXM), .SCORE_W(2)) dut2 (
        .clk(clk), .reset_n(reset_n), .start(start), .rand_idx(rand_idx), .btn(btn),
        .mole(mole2), .score(score2), .miss_cnt(miss_cnt2), .hit_pulse(hit_pulse2),
        .miss_pulse(miss_pulse2), .game_over(game_over2), .busy(busy2)
    );

    always #5 clk = ~clk;

    int nChecks = 0;
    int nFail   = 0;

    // Mole-level reference model state.
    int         mScore;
    int         mMiss;
    int         mLimit;
    bit         mFirst;
    logic [1:0] mLast;

    typedef struct {
        logic [1:0] ridx;
        logic [1:0] hole;
        int         strikeAt;
        bit         preHeld;
        bit         distract;
        int         expScore;
        int         expMiss;
    } moleVec_t;

    moleVec_t vecs[6];

    task automatic tick;
        @(posedge clk);
        #1;
    endtask

    task automatic checkOutput(input string name, input int actual, input int expected);
        nChecks++;
        if (actual != expected) begin
            nFail++;
            $display("[TB] FAIL %s: got %0d, expected %0d", name, actual, expected);
        end
    endtask

    task automatic applyStimulus(input logic st, input logic [1:0] ridx, input logic [3:0] b);
        start    = st;
        rand_idx = ridx;
        btn      = b;
    endtask

    function automatic logic [1:0] predictHole(input logic [1:0] r);
        if (!mFirst && r == mLast) return r + 2'd1;
        return r;
    endfunction

    function automatic int sat2(input int s);
        return (s > 3) ? 3 : s;
    endfunction

    task automatic checkAllZero(input string tag);
        checkOutput({tag, "_mole"}, mole, 0);
        checkOutput({tag, "_score"}, score, 0);
        checkOutput({tag, "_miss"}, miss_cnt, 0);
        checkOutput({tag, "_hitp"}, hit_pulse, 0);
        checkOutput({tag, "_missp"}, miss_pulse, 0);
        checkOutput({tag, "_over"}, game_over, 0);
        checkOutput({tag, "_busy"}, busy, 0);
        checkOutput({tag, "_mole2"}, mole2, 0);
        checkOutput({tag, "_score2"}, score2, 0);
        checkOutput({tag, "_miss2"}, miss_cnt2, 0);
        checkOutput({tag, "_pulses2"}, {hit_pulse2, miss_pulse2}, 0);
        checkOutput({tag, "_flags2"}, {game_over2, busy2}, 0);
    endtask

    // From IDLE or OVER: one start cycle leaves the DUT in SPAWN.
    task automatic startGame;
        applyStimulus(1'b1, rand_idx, 4'd0);
        tick();
        start = 1'b0;
        checkOutput("start_busy", busy, 1);
        checkOutput("start_over", game_over, 0);
        checkOutput("start_mole", mole, 0);
        checkOutput("start_score", score, 0);
        checkOutput("start_miss", miss_cnt, 0);
        mScore = 0;
        mMiss  = 0;
        mFirst = 1'b1;
        mLimit = UP;
    endtask

    // Plays one mole, starting in SPAWN. It ends in the next SPAWN, or in OVER.
    task automatic doMole(input logic [1:0] ridx, input logic [1:0] expHole, input int strikeAt,
                          input bit preHeld, input bit distract, output bit over);
        int         win;
        bit         hit;
        logic [1:0] other;
        win   = mLimit;
        hit   = !preHeld && strikeAt >= 1 && strikeAt <= win;
        other = expHole + 2'd2;
        rand_idx = ridx;
        btn      = 4'd0;
        if (preHeld) btn[expHole] = 1'b1;
        checkOutput("spawn_mole", mole, 0);
        checkOutput("spawn_busy", busy, 1);
        tick();
        for (int c = 1; c <= win; c++) begin
            checkOutput("up_mole", mole, 4'b0001 << expHole);
            if (distract && c == 1) btn[other] = 1'b1;
            if (hit && c == strikeAt) btn[expHole] = 1'b1;
            tick();
            if (hit && c == strikeAt) break;
        end
        btn = 4'd0;
        checkOutput("end_mole", mole, 0);
        checkOutput("hit_pulse", hit_pulse, hit ? 1 : 0);
        checkOutput("miss_pulse", miss_pulse, hit ? 0 : 1);
        if (hit) begin
            mScore++;
`ifdef MOLE_SPEEDUP_EN
            mLimit = (mLimit - UP / 16 < UP / 4) ? UP / 4 : mLimit - UP / 16;
`endif
        end else begin
            mMiss++;
        end
        mLast  = expHole;
        mFirst = 1'b0;
        tick();
        if (mMiss == MAXM) begin
            checkOutput("over_flag", game_over, 1);
            checkOutput("over_busy", busy, 0);
            checkOutput("over_mole", mole, 0);
            checkOutput("over_miss", miss_cnt, MAXM);
            checkOutput("over_score", score, mScore);
            over = 1'b1;
            return;
        end
        over = 1'b0;
        for (int g = 1; g <= GAP; g++) begin
            checkOutput("gap_mole", mole, 0);
            checkOutput("gap_busy", busy, 1);
            checkOutput("gap_pulses", {hit_pulse, miss_pulse}, 0);
            if (g == 1) begin
                checkOutput("gap_score", score, mScore);
                checkOutput("gap_score2", score2, sat2(mScore));
                checkOutput("gap_miss", miss_cnt, mMiss);
            end
            tick();
        end
    endtask

    initial begin
        bit         over;
        logic [1:0] r;
        logic [1:0] h;

        // Directed game: hit, wrong-button miss, repeat-avoid hit on the
        // timeout cycle, held-button miss, hit, and a final miss that ends the game.
        vecs[0] = '{2'd2, 2'd2, 3, 1'b0, 1'b0, 1, 0};
        vecs[1] = '{2'd3, 2'd3, 0, 1'b0, 1'b1, 1, 1};
        vecs[2] = '{2'd3, 2'd0, 8, 1'b0, 1'b0, 2, 1};
        vecs[3] = '{2'd1, 2'd1, 2, 1'b1, 1'b0, 2, 2};
        vecs[4] = '{2'd0, 2'd0, 1, 1'b0, 1'b0, 3, 2};
        vecs[5] = '{2'd0, 2'd1, 0, 1'b0, 1'b0, 3, 3};

        $display("[TB] reset");
        applyStimulus(1'b0, 2'd0, 4'd0);
        reset_n = 1'b0;
        tick();
        tick();
        checkAllZero("reset");
        reset_n = 1'b1;
        tick();
        checkOutput("idle_busy", busy, 0);

        $display("[TB] directed game");
        startGame();
        for (int i = 0; i < 6; i++) begin
            doMole(vecs[i].ridx, vecs[i].hole, vecs[i].strikeAt, vecs[i].preHeld, vecs[i].distract, over);
            checkOutput("tbl_score", score, vecs[i].expScore);
            checkOutput("tbl_miss", miss_cnt, vecs[i].expMiss);
            checkOutput("tbl_over", over, (i == 5) ? 1 : 0);
        end

        // OVER holds its state and ignores buttons until start.
        for (int i = 0; i < 3; i++) begin
            btn = 4'(i + 1);
            tick();
            checkOutput("hold_over", game_over, 1);
            checkOutput("hold_busy", busy, 0);
            checkOutput("hold_mole", mole, 0);
            checkOutput("hold_score", score, 3);
            checkOutput("hold_miss", miss_cnt, 3);
        end
        btn = 4'd0;

        $display("[TB] saturation");
        startGame();
        for (int i = 0; i < 5; i++) begin
            r = 2'($urandom_range(0, 3));
            h = predictHole(r);
            doMole(r, h, 2, 1'b0, 1'b0, over);
        end
        checkOutput("sat_score", score, 5);
        checkOutput("sat_score2", score2, 3);

        $display("[TB] start while busy, reset in UP");
        h = predictHole(2'd1);
        rand_idx = 2'd1;
        tick();
        checkOutput("busy_mole", mole, 4'b0001 << h);
        start = 1'b1;
        tick();
        checkOutput("busy_start_mole", mole, 4'b0001 << h);
        checkOutput("busy_start_score", score, 5);
        checkOutput("busy_start_busy", busy, 1);
        reset_n = 1'b0;
        tick();
        reset_n = 1'b1;
        start   = 1'b0;
        checkAllZero("midreset");
        tick();
        checkOutput("midreset_idle", busy, 0);

        $display("[TB] random games");
        for (int g = 0; g < 4; g++) begin
            startGame();
            over = 1'b0;
            for (int m = 0; m < 30 && !over; m++) begin
                r = 2'($urandom_range(0, 3));
                h = predictHole(r);
                doMole(r, h, int'($urandom_range(0, mLimit + 2)), ($urandom_range(0, 5) == 0),
                       ($urandom_range(0, 2) == 0), over);
                checkOutput("rnd_score", score, mScore);
                checkOutput("rnd_score2", score2, sat2(mScore));
                checkOutput("rnd_miss", miss_cnt, mMiss);
            end
            if (!over) begin
                reset_n = 1'b0;
                tick();
                reset_n = 1'b1;
                checkOutput("rnd_reset_busy", busy, 0);
            end
        end

        $display("End of test - %0d assertions evaluated, %0d failures", nChecks, nFail);
        $finish;
    end

endmodule
